neuron_acc_pipe: RTL and testbench
==================================

Name: neuron_acc_pipe

Overview:
- Parametrised successor to the single-neuron bias accumulator in the MNIST datapath.
- Sums N_TERMS signed products from the multiplier stage, seeds the sum with a signed bias, and saturates the result to ACC_W bits.
- Term counting and sequencing are built in; no external controller is needed.
- Valid/ready handshakes on input and output sit between the MAC multiplier and the activation/argmax stage.

Parameters:
- DIN_W, 20, signed product width (din)
- BIAS_W, 8, signed bias width
- ACC_W, 22, signed accumulator/result width; must be >= DIN_W+1 and >= BIAS_W
- N_TERMS, 784, products per neuron; must be >= 1
- CNT_W, $clog2(N_TERMS+1), term counter width (derived; do not override)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset; asserted when 0
- clr  in  1  synchronous abort; discards the partial sum and returns the block to ACCUM with the counter at 0
- in_valid  in  1  din/bias valid
- in_ready  out  1  block accepts a term
- din  in  DIN_W  signed product term
- b  in  BIAS_W  signed bias; sampled only on the first term of a neuron
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out  out  ACC_W  signed saturated result
- ovf  out  1  set when any saturation occurred while computing the current result

Behaviour:
- Reset (rst=0, asynchronous): state=ACCUM, cnt=0, acc=0, out=0, out_valid=0, ovf=0, ovf_run=0.
- States: ACCUM and HOLD.
- in_ready = (state==ACCUM).
- Input handshake: in_valid & in_ready on a rising clk edge.
- On each input handshake in ACCUM:
  - base = (cnt==0) ? sign_ext(b) : acc
  - s = sign_ext(base, ACC_W+1) + sign_ext(din, ACC_W+1)
  - If s > 2^(ACC_W-1)-1, acc = max positive and ovf_run is set. If s < -2^(ACC_W-1), acc = min negative and ovf_run is set. Otherwise acc = s.
  - ovf_run is cleared to 0 when cnt==0, before OR-ing in any saturation on that term.
  - If cnt == N_TERMS-1: out <= saturated s, ovf <= final ovf_run, out_valid <= 1, cnt <= 0, state <= HOLD. Otherwise cnt <= cnt+1.
- Latency: out_valid rises on the clock edge that accepts the last term. Result is visible 1 cycle after the last handshake.
- No input handshake (in_valid=0): acc and cnt hold.
- HOLD:
  - in_ready=0.
  - out, ovf and out_valid stay stable until out_valid & out_ready.
  - On that edge: out_valid <= 0, state <= ACCUM.
  - out and ovf keep their last values after out_valid drops.
- Throughput: one result per N_TERMS+1 cycles minimum, because HOLD lasts at least one cycle.
- N_TERMS=1: every accepted term completes a neuron; out = sat(b + din).
- clr=1:
  - In ACCUM: cnt <= 0 and ovf_run <= 0. Any coincident input handshake is ignored; clr has priority.
  - In HOLD: clr does not affect out or out_valid; the pending result must still be consumed.
- out_ready in ACCUM is ignored.
- Reset mid-neuron: the partial sum is lost and no output is produced.
- The counter never exceeds N_TERMS-1. There is no wrap-around path other than the completion path.

Optional Feature:
- Macro: NEURON_ACC_RELU_EN.
- Defined: the value registered into out on completion is max(sat_result, 0), i.e. negative results are written as 0. ovf still reflects saturation of the pre-ReLU sum.
- Undefined: out is the signed saturated sum, unmodified. Port list is identical in both builds.

Test Plan:
- Reset/idle: rst=0 then release; idle for 5 cycles -> out=0, out_valid=0, ovf=0, in_ready=1.
- Basic sum (N_TERMS=4): b=5 on first term, din=10,-3,7,1 with in_valid held high -> out_valid rises 1 cycle after the 4th handshake, out=20, ovf=0; in_ready=0 until out_ready.
- Backpressure and gaps (N_TERMS=4): in_valid toggled 1,0,1,0,...; out_ready held 0 for 6 cycles -> out stays 20 and stable; the next neuron (b=-2, din=1,1,1,1) yields out=2 after out_ready pulse.
- Saturation (N_TERMS=4, ACC_W=22): b=127, din=+524287 four times -> out=2097151, ovf=1. Following neuron b=0, din=1,1,1,1 -> out=4, ovf=0.
- clr mid-neuron: after 2 terms, pulse clr with in_valid=1 and din=100 -> that term is ignored; next 4 terms b=1, din=1,1,1,1 -> out=5.
- Negative result and macro: b=-10, din=-1,-1,-1,-1 -> out=-14 without NEURON_ACC_RELU_EN, out=0 with it; async rst during HOLD -> out_valid drops immediately.

Source files
------------

// File: rtl/neuron_acc_pipe.sv
// neuron_acc_pipe
// Accumulates N_TERMS signed products per neuron, seeded with a signed bias
// taken on the first term, and saturates every partial sum to ACC_W bits.
// The finished result is held behind a valid/ready output handshake; no new
// terms are accepted until it has been consumed.
//
// Optional build macro: NEURON_ACC_RELU_EN
//   defined   -> negative results are written to out as 0 (ovf still reports
//                saturation of the pre-ReLU sum)
//   undefined -> out is the signed saturated sum
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active low
//   clr        in   synchronous abort of the partial sum (ignored in HOLD)
//   in_valid   in   din/bias valid
//   in_ready   out  block accepts a term (high in ACCUM)
//   din        in   DIN_W signed product term
//   b          in   BIAS_W signed bias, used on the first term only
//   out_valid  out  result valid
//   out_ready  in   downstream accepts result
//   out        out  ACC_W signed saturated result
//   ovf        out  saturation happened somewhere in the current result
//
// state | meaning
// ACCUM | accepting terms, cnt_q counts terms taken for this neuron
// HOLD  | result presented, waiting for out_ready

module neuron_acc_pipe #(
  parameter int DIN_W   = 20,
  parameter int BIAS_W  = 8,
  parameter int ACC_W   = 22,
  parameter int N_TERMS = 784,
  parameter int CNT_W   = $clog2(N_TERMS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [DIN_W-1:0] din,
  input  logic signed [BIAS_W-1:0] b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out,
  output logic                    ovf
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam logic signed [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(N_TERMS - 1);

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    ovf_run_q, ovf_run_d;
  logic signed [ACC_W-1:0] out_q, out_d;
  logic                    ovf_q;
  logic                    out_valid_q;

  logic                    first_term;
  logic                    in_hs;
  logic signed [ACC_W:0]   base_ext;
  logic signed [ACC_W:0]   din_ext;
  logic signed [ACC_W:0]   sum;
  logic                    sat_pos, sat_neg;

  assign in_ready  = (state_q == ACCUM);
  assign in_hs     = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign ovf       = ovf_q;

  always_comb begin
    first_term = (cnt_q == '0);
    din_ext    = {{(ACC_W+1-DIN_W){din[DIN_W-1]}}, din};
    base_ext   = first_term ? {{(ACC_W+1-BIAS_W){b[BIAS_W-1]}}, b}
                            : {acc_q[ACC_W-1], acc_q};
    // Both operands fit in ACC_W bits, so the ACC_W+1 sum cannot wrap; a
    // mismatch between its top two bits means the result is out of range.
    sum        = base_ext + din_ext;
    sat_pos    = ~sum[ACC_W] &  sum[ACC_W-1];
    sat_neg    =  sum[ACC_W] & ~sum[ACC_W-1];
    acc_d      = sat_pos ? ACC_MAX : (sat_neg ? ACC_MIN : sum[ACC_W-1:0]);
    ovf_run_d  = (first_term ? 1'b0 : ovf_run_q) | sat_pos | sat_neg;
`ifdef NEURON_ACC_RELU_EN
    out_d      = acc_d[ACC_W-1] ? '0 : acc_d;
`else
    out_d      = acc_d;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      acc_q       <= '0;
      ovf_run_q   <= 1'b0;
      out_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (clr) begin
            // acc_q need not be cleared: the next term reseeds from b.
            cnt_q     <= '0;
            ovf_run_q <= 1'b0;
          end else if (in_hs) begin
            acc_q     <= acc_d;
            ovf_run_q <= ovf_run_d;
            if (cnt_q == LAST_CNT) begin
              out_q       <= out_d;
              ovf_q       <= ovf_run_d;
              out_valid_q <= 1'b1;
              cnt_q       <= '0;
              state_q     <= HOLD;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_acc_pipe.sv
module tb_neuron_acc_pipe;

  localparam int DIN_W   = 20;
  localparam int BIAS_W  = 8;
  localparam int ACC_W   = 22;
  localparam int N_TERMS = 4;

`ifdef NEURON_ACC_RELU_EN
  localparam int EXP_NEG14 = 0;
  localparam int EXP_MIN   = 0;
`else
  localparam int EXP_NEG14 = -14;
  localparam int EXP_MIN   = -2097152;
`endif

  logic                     clk;
  logic                     rst;
  logic                     clr;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DIN_W-1:0]  din;
  logic signed [BIAS_W-1:0] b;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out;
  logic                     ovf;

  int n_assert = 0;
  int n_fail   = 0;

  neuron_acc_pipe #(
    .DIN_W  (DIN_W),
    .BIAS_W (BIAS_W),
    .ACC_W  (ACC_W),
    .N_TERMS(N_TERMS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .din      (din),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle with the given inputs; the edge samples them, outputs are then
  // observed 1 time unit after the edge.
  task automatic feed(input bit vld, input int bb, input int dd);
    in_valid = vld;
    b        = BIAS_W'(bb);
    din      = DIN_W'(dd);
    tick();
    in_valid = 1'b0;
  endtask

  // Four back-to-back terms; out_valid must stay low until the last one.
  task automatic neuron(input string tag, input int bb,
                        input int d0, input int d1, input int d2, input int d3);
    feed(1'b1, bb, d0);
    feed(1'b1, 0, d1);
    feed(1'b1, 0, d2);
    check({tag, "_early_valid"}, int'(out_valid), 0);
    feed(1'b1, 0, d3);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    din = '0; b = '0;
    #23 rst = 1'b1;
    repeat (5) tick();
    check("rst_out",       int'(out),       0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_ovf",       int'(ovf),       0);
    check("rst_in_ready",  int'(in_ready),  1);

    // basic sum: 5+10-3+7+1
    neuron("basic", 5, 10, -3, 7, 1);
    check("basic_valid", int'(out_valid), 1);
    check("basic_out",   int'(out),       20);
    check("basic_ovf",   int'(ovf),       0);
    check("basic_ready", int'(in_ready),  0);

    // backpressure: terms offered during HOLD must be ignored
    for (int i = 0; i < 6; i++) feed(1'b1, 9, 999);
    check("bp_valid", int'(out_valid), 1);
    check("bp_out",   int'(out),       20);
    check("bp_ready", int'(in_ready),  0);
    consume();
    check("pop_valid", int'(out_valid), 0);
    check("pop_ready", int'(in_ready),  1);
    check("pop_out",   int'(out),       20);

    // gaps: invalid cycles carry junk that must not be summed
    feed(1'b1, -2, 1);  feed(1'b0, 50, 50);
    feed(1'b1, 50, 1);  feed(1'b0, 50, 50);
    feed(1'b1, 50, 1);  feed(1'b0, 50, 50);
    check("gap_early_valid", int'(out_valid), 0);
    feed(1'b1, 50, 1);
    check("gap_valid", int'(out_valid), 1);
    check("gap_out",   int'(out),       2);
    consume();

    // positive saturation, then ovf must clear on the next neuron
    neuron("satp", 127, 524287, 524287, 524287, 524287);
    check("satp_out", int'(out), 2097151);
    check("satp_ovf", int'(ovf), 1);
    consume();
    check("satp_ovf_kept", int'(ovf), 1);
    neuron("post", 0, 1, 1, 1, 1);
    check("post_out", int'(out), 4);
    check("post_ovf", int'(ovf), 0);
    consume();

    // negative saturation
    neuron("satn", -128, -524288, -524288, -524288, -524288);
    check("satn_out", int'(out), EXP_MIN);
    check("satn_ovf", int'(ovf), 1);
    consume();

    // clr mid-neuron with a coincident valid term
    feed(1'b1, 7, 3);
    feed(1'b1, 7, 3);
    clr = 1'b1;
    feed(1'b1, 7, 100);
    clr = 1'b0;
    neuron("clr", 1, 1, 1, 1, 1);
    check("clr_valid", int'(out_valid), 1);
    check("clr_out",   int'(out),       5);
    consume();

    // negative result
    neuron("neg", -10, -1, -1, -1, -1);
    check("neg_out", int'(out), EXP_NEG14);
    check("neg_ovf", int'(ovf), 0);
    // clr in HOLD leaves the pending result alone
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("hclr_valid", int'(out_valid), 1);
    check("hclr_out",   int'(out),       EXP_NEG14);
    // asynchronous reset during HOLD
    #3 rst = 1'b0;
    #1;
    check("arst_valid", int'(out_valid), 0);
    check("arst_out",   int'(out),       0);
    check("arst_ready", int'(in_ready),  1);
    #2 rst = 1'b1;
    tick();

    // reset mid-neuron discards the partial sum
    feed(1'b1, 50, 40);
    feed(1'b1, 50, 40);
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    tick();
    check("rmid_valid", int'(out_valid), 0);
    neuron("rmid", 0, 2, 2, 2, 2);
    check("rmid_out", int'(out), 8);
    consume();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
